// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one full-adder cell, LSB first
// Optional subtract mode: define SERIAL_ADDER_SUB_EN to add the sub port.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nxt, b_load;
  logic [CW-1:0]    cnt;
  logic             carry, c_load, fa_s, fa_c, last_bit;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as A + ~B + 1: invert B on load and force the carry in.
  assign b_load = sub ? ~B : B;
  assign c_load = sub | C_in;
`else
  assign b_load = B;
  assign c_load = C_in;
`endif

  assign fa_s     = a_sr[0] ^ b_sr[0] ^ carry;
  assign fa_c     = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign sum_nxt  = {fa_s, sum_sr[WIDTH-1:1]};
  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        state_nxt = last_bit ? DONE : SHIFT;
      end
      DONE: begin
        done   = 1'b1;
        accept = start;
        if (start) state_nxt = SHIFT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      S      <= '0;
      C_out  <= 1'b0;
    end else if (accept) begin
      a_sr  <= A;
      b_sr  <= b_load;
      carry <= c_load;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= sum_nxt;
      carry  <= fa_c;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        S     <= sum_nxt;
        C_out <= fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder (WIDTH=8)
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         C_in = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, C_out;
  logic [W-1:0] S;

  int           n_cmp = 0;
  int           n_err = 0;
  int           done_count = 0;
  logic [W:0]   sb[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .C_in(C_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .S(S), .C_out(C_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic s);
    if (s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  // Result monitor: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      done_count++;
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else check("result", {C_out, S}, sb.pop_front());
    end
  end

  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic s);
    @(negedge clk);
    A = a; B = b; C_in = cin; sub = s; start = 1'b1;
    sb.push_back(model(a, b, cin, s));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 4 * W) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic s);
    int cyc;
    drive_start(a, b, cin, s);
    wait_done(cyc);
    check("latency", cyc, W);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    int cyc, dc;
    #2 rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", {C_out, S}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_add(8'h5A, 8'h3C, 1'b0, 1'b0);
    do_add(8'hFF, 8'h01, 1'b0, 1'b0);
    do_add(8'hFF, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++)
      do_add(W'($urandom), W'($urandom), 1'($urandom), 1'b0);

    // Start while busy is ignored
    drive_start(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    A = 8'hFF; B = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dc = done_count;
    wait_done(cyc);
    check("ignore_latency", cyc, W - 4);
    repeat (2 * W) @(negedge clk);
    check("ignore_one_done", done_count - dc, 1);

    // Back-to-back: start held into DONE
    drive_start(8'h0F, 8'h01, 1'b0, 1'b0);
    repeat (W - 1) @(negedge clk);
    A = 8'h80; B = 8'h80; C_in = 1'b0; start = 1'b1;
    sb.push_back(model(8'h80, 8'h80, 1'b0, 1'b0));
    @(negedge clk);
    check("b2b_first_done", done, 1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_gap_busy", busy, 1);
    check("b2b_done_drop", done, 0);
    wait_done(cyc);
    check("b2b_latency", cyc, W);
    @(negedge clk);

    // Reset mid-operation aborts with no done
    drive_start(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    void'(sb.pop_back());
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sum", {C_out, S}, 0);
    dc = done_count;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * W) @(negedge clk);
    check("midrst_no_done", done_count - dc, 0);
    do_add(8'h01, 8'h01, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    do_add(8'h10, 8'h01, 1'b0, 1'b1);
    do_add(8'h01, 8'h02, 1'b1, 1'b1);
    do_add(8'h33, 8'h11, 1'b1, 1'b0);
`endif

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
